// File: rtl/nw_pkg.sv
// Shared types and helpers for the systolic Needleman-Wunsch scorer.
// Boundary scores are k*INDEL; callers size the result to their score width.
package nw_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_C = 2'd1;
  localparam logic [1:0] CH_G = 2'd2;
  localparam logic [1:0] CH_T = 2'd3;

  function automatic int boundary_score(input int k, input int indel);
    return k * indel;
  endfunction

endpackage

// File: rtl/nw_pe.sv
// One column of the systolic array: computes H[i+1][j+1] for the s2 char
// currently passing through, and forwards that char to the next column.
module nw_pe
  import nw_pkg::*;
#(
  parameter int CWIDTH   = 2,
  parameter int SWIDTH   = 16,
  parameter int MATCH    = 1,
  parameter int MISMATCH = -1,
  parameter int INDEL    = -1,
  parameter int COL_IDX  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_i,
  input  logic                     shift_i,
  input  logic                     en_i,
  input  logic [CWIDTH-1:0]        s1_char_i,
  input  logic [CWIDTH-1:0]        char_i,
  input  logic signed [SWIDTH-1:0] left_i,
  output logic [CWIDTH-1:0]        char_o,
  output logic signed [SWIDTH-1:0] score_o
);

  localparam logic signed [SWIDTH-1:0] W_MATCH     = SWIDTH'(MATCH);
  localparam logic signed [SWIDTH-1:0] W_MISMATCH  = SWIDTH'(MISMATCH);
  localparam logic signed [SWIDTH-1:0] W_INDEL     = SWIDTH'(INDEL);
  localparam logic signed [SWIDTH-1:0] INIT_ABOVE  = SWIDTH'(boundary_score(COL_IDX + 1, INDEL));
  localparam logic signed [SWIDTH-1:0] INIT_CORNER = SWIDTH'(boundary_score(COL_IDX, INDEL));

  logic [CWIDTH-1:0]        char_q;
  // score_q is both this column's output and its "above" value for the next row.
  logic signed [SWIDTH-1:0] score_q;
  logic signed [SWIDTH-1:0] corner_q;

  logic signed [SWIDTH-1:0] diag_cand;
  logic signed [SWIDTH-1:0] up_cand;
  logic signed [SWIDTH-1:0] left_cand;
  logic signed [SWIDTH-1:0] best;

  always_comb begin
    diag_cand = corner_q + ((char_i == s1_char_i) ? W_MATCH : W_MISMATCH);
    up_cand   = score_q + W_INDEL;
    left_cand = left_i + W_INDEL;
    best      = diag_cand;
    if (up_cand > best) begin
      best = up_cand;
    end
    if (left_cand > best) begin
      best = left_cand;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_q   <= '0;
      score_q  <= '0;
      corner_q <= '0;
    end else begin
      if (shift_i) begin
        char_q <= char_i;
      end
      if (load_i) begin
        score_q  <= INIT_ABOVE;
        corner_q <= INIT_CORNER;
      end else if (en_i) begin
        score_q  <= best;
        corner_q <= left_i;
      end
    end
  end

  assign char_o  = char_q;
  assign score_o = score_q;

endmodule

// File: rtl/nw_systolic_scorer.sv
// Linear systolic Needleman-Wunsch global-alignment scorer: one PE per s1 char,
// s2 streams through on an anti-diagonal wavefront under a start/busy/done handshake.
module nw_systolic_scorer
  import nw_pkg::*;
#(
  parameter int MAX_LEN  = 16,
  parameter int CWIDTH   = 2,
  parameter int SWIDTH   = 16,
  parameter int LWIDTH   = $clog2(MAX_LEN + 1),
  parameter int MATCH    = 1,
  parameter int MISMATCH = -1,
  parameter int INDEL    = -1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [MAX_LEN*CWIDTH-1:0] s1,
  input  logic [MAX_LEN*CWIDTH-1:0] s2,
  input  logic [LWIDTH-1:0]         len1,
  input  logic [LWIDTH-1:0]         len2,
  output logic                      busy,
  output logic                      done,
  output logic signed [SWIDTH-1:0]  score
);

  localparam int TWIDTH = LWIDTH + 1;
  localparam int IWIDTH = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_e                   state_q, state_d;
  logic [TWIDTH-1:0]        t_q, t_d;
  logic [LWIDTH-1:0]        len1_q, len1_d;
  logic [LWIDTH-1:0]        len2_q, len2_d;
  logic                     done_q, done_d;
  logic signed [SWIDTH-1:0] score_q, score_d;
  logic [CWIDTH-1:0]        s1_q [MAX_LEN];
  logic [CWIDTH-1:0]        s2_q [MAX_LEN];

  logic                     accept;
  logic                     run;
  logic                     last_wave;
  logic                     degenerate;
  logic [LWIDTH-1:0]        len1_clamp;
  logic [LWIDTH-1:0]        len2_clamp;
  logic [IWIDTH-1:0]        last_col;
  logic [CWIDTH-1:0]        feed_char;
  logic signed [SWIDTH-1:0] feed_left;
  logic signed [SWIDTH-1:0] degen_score;
  logic [CWIDTH-1:0]        pe_char  [MAX_LEN];
  logic signed [SWIDTH-1:0] pe_score [MAX_LEN];

  assign len1_clamp  = (len1 > LWIDTH'(MAX_LEN)) ? LWIDTH'(MAX_LEN) : len1;
  assign len2_clamp  = (len2 > LWIDTH'(MAX_LEN)) ? LWIDTH'(MAX_LEN) : len2;
  assign last_wave   = (t_q == ({1'b0, len1_q} + {1'b0, len2_q} - TWIDTH'(2)));
  assign degenerate  = (len1_q == '0) || (len2_q == '0);
  assign last_col    = IWIDTH'(len1_q - 1'b1);
  assign degen_score = SWIDTH'(boundary_score(int'(len1_q) + int'(len2_q), INDEL));

  // PE0 sees s2 char t with the column-0 boundary H[t+1][0] on its left.
  assign feed_char = (t_q < {1'b0, len2_q}) ? s2_q[t_q[IWIDTH-1:0]] : '0;
  assign feed_left = SWIDTH'(boundary_score(int'(t_q) + 1, INDEL));

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    len1_d  = len1_q;
    len2_d  = len2_q;
    done_d  = 1'b0;
    score_d = score_q;
    accept  = 1'b0;
    run     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          len1_d  = len1_clamp;
          len2_d  = len2_clamp;
          t_d     = '0;
          state_d = ((len1_clamp == '0) || (len2_clamp == '0)) ? FINISH : RUN;
        end
      end
      RUN: begin
        run = 1'b1;
        t_d = t_q + 1'b1;
        if (last_wave) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        score_d = degenerate ? degen_score : pe_score[last_col];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      len1_q  <= '0;
      len2_q  <= '0;
      done_q  <= 1'b0;
      score_q <= '0;
      for (int k = 0; k < MAX_LEN; k++) begin
        s1_q[k] <= '0;
        s2_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      len1_q  <= len1_d;
      len2_q  <= len2_d;
      done_q  <= done_d;
      score_q <= score_d;
      if (accept) begin
        for (int k = 0; k < MAX_LEN; k++) begin
          s1_q[k] <= s1[k*CWIDTH +: CWIDTH];
          s2_q[k] <= s2[k*CWIDTH +: CWIDTH];
        end
      end
    end
  end

  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_pe
    localparam logic [TWIDTH-1:0] COL = TWIDTH'(gi);
    logic [TWIDTH:0]          row_diff;
    logic                     pe_en;
    logic [CWIDTH-1:0]        char_in;
    logic signed [SWIDTH-1:0] left_in;

    // Column gi works on row t-gi; the sign bit of the difference marks "not yet reached".
    assign row_diff = {1'b0, t_q} - {1'b0, COL};
    assign pe_en    = run && (COL < {1'b0, len1_q}) && !row_diff[TWIDTH]
                      && (row_diff[TWIDTH-1:0] < {1'b0, len2_q});

    if (gi == 0) begin : g_head
      assign char_in = feed_char;
      assign left_in = feed_left;
    end else begin : g_body
      assign char_in = pe_char[gi-1];
      assign left_in = pe_score[gi-1];
    end

    nw_pe #(
      .CWIDTH  (CWIDTH),
      .SWIDTH  (SWIDTH),
      .MATCH   (MATCH),
      .MISMATCH(MISMATCH),
      .INDEL   (INDEL),
      .COL_IDX (gi)
    ) u_pe (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (accept),
      .shift_i  (run),
      .en_i     (pe_en),
      .s1_char_i(s1_q[gi]),
      .char_i   (char_in),
      .left_i   (left_in),
      .char_o   (pe_char[gi]),
      .score_o  (pe_score[gi])
    );
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign score = score_q;

endmodule

// File: tb/tb_nw_systolic_scorer.sv
// Self-checking bench for nw_systolic_scorer: directed alignments, handshake
// corner cases and randomized strings against a plain dynamic-programming model.
module tb_nw_systolic_scorer;

  localparam int MAX_LEN  = 16;
  localparam int SWIDTH   = 16;
  localparam int LWIDTH   = 5;
  localparam int MATCH    = 1;
  localparam int MISMATCH = -1;
  localparam int INDEL    = -1;

  logic                     clk;
  logic                     rst_n;
  logic                     start;
  logic [31:0]              s1;
  logic [31:0]              s2;
  logic [LWIDTH-1:0]        len1;
  logic [LWIDTH-1:0]        len2;
  logic                     busy;
  logic                     done;
  logic signed [SWIDTH-1:0] score;

  int total;
  int bad;

  nw_systolic_scorer dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .s1   (s1),
    .s2   (s2),
    .len1 (len1),
    .len2 (len2),
    .busy (busy),
    .done (done),
    .score(score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input string s);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < s.len(); k++) begin
      case (s[k])
        "A": v[2*k +: 2] = 2'd0;
        "C": v[2*k +: 2] = 2'd1;
        "G": v[2*k +: 2] = 2'd2;
        default: v[2*k +: 2] = 2'd3;
      endcase
    end
    return v;
  endfunction

  // Textbook DP matrix over the clamped lengths.
  function automatic int ref_nw(input logic [31:0] a, input logic [31:0] b,
                                input int la, input int lb);
    int h [0:16][0:16];
    int n1;
    int n2;
    int d;
    int u;
    int l;
    n1 = (la > MAX_LEN) ? MAX_LEN : la;
    n2 = (lb > MAX_LEN) ? MAX_LEN : lb;
    for (int i = 0; i <= n2; i++) h[i][0] = i * INDEL;
    for (int j = 0; j <= n1; j++) h[0][j] = j * INDEL;
    for (int i = 1; i <= n2; i++) begin
      for (int j = 1; j <= n1; j++) begin
        d = h[i-1][j-1] + ((b[2*(i-1) +: 2] == a[2*(j-1) +: 2]) ? MATCH : MISMATCH);
        u = h[i-1][j] + INDEL;
        l = h[i][j-1] + INDEL;
        h[i][j] = d;
        if (u > h[i][j]) h[i][j] = u;
        if (l > h[i][j]) h[i][j] = l;
      end
    end
    return h[n2][n1];
  endfunction

  function automatic int exp_latency(input int la, input int lb);
    int n1;
    int n2;
    n1 = (la > MAX_LEN) ? MAX_LEN : la;
    n2 = (lb > MAX_LEN) ? MAX_LEN : lb;
    return (n1 == 0 || n2 == 0) ? 1 : n1 + n2;
  endfunction

  // Presents a request for one edge; returns #1 after the accept edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input int la, input int lb);
    @(negedge clk);
    s1 = a;
    s2 = b;
    len1 = LWIDTH'(la);
    len2 = LWIDTH'(lb);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges until done; edge_n=-1 if the budget expires.
  task automatic wait_done(output int edge_n, output logic signed [SWIDTH-1:0] sc,
                           output bit busy_ok);
    edge_n = -1;
    sc = '0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        edge_n = k;
        sc = score;
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    s1 = '0;
    s2 = '0;
    len1 = '0;
    len2 = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++;
    if (score !== '0) begin bad++; $display("FAIL reset_score got=%0d want=0", score); end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_known;
    string a_tab [4] = '{"ACGT", "ACGT", "ACGT", "AGT"};
    string b_tab [4] = '{"ACGT", "TGCA", "AGT",  "ACGT"};
    int    sc_tab [4] = '{4, -3, 2, 2};
    int    ed_tab [4] = '{8, 8, 7, 7};
    int edge_n;
    logic signed [SWIDTH-1:0] sc;
    bit busy_ok;
    for (int n = 0; n < 4; n++) begin
      launch(enc(a_tab[n]), enc(b_tab[n]), a_tab[n].len(), b_tab[n].len());
      wait_done(edge_n, sc, busy_ok);
      $display("known %s vs %s score=%0d edge=%0d", a_tab[n], b_tab[n], sc, edge_n);
      total++;
      if (sc !== SWIDTH'(sc_tab[n])) begin
        bad++; $display("FAIL known_score[%0d] got=%0d want=%0d", n, sc, sc_tab[n]);
      end
      total++;
      if (edge_n != ed_tab[n]) begin
        bad++; $display("FAIL known_latency[%0d] got=%0d want=%0d", n, edge_n, ed_tab[n]);
      end
      total++;
      if (!busy_ok) begin bad++; $display("FAIL known_busy[%0d] got=0 want=1", n); end
      @(posedge clk);
      #1;
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL known_done_pulse[%0d] got=%b want=0", n, done); end
      total++;
      if (score !== SWIDTH'(sc_tab[n])) begin
        bad++; $display("FAIL known_score_hold[%0d] got=%0d want=%0d", n, score, sc_tab[n]);
      end
    end
  endtask

  task automatic test_degenerate;
    int la_tab [3] = '{1, 0, 0};
    int lb_tab [3] = '{0, 0, 5};
    int edge_n;
    logic signed [SWIDTH-1:0] sc;
    bit busy_ok;
    for (int n = 0; n < 3; n++) begin
      launch(enc("ACGTACGT"), enc("GGCCAATT"), la_tab[n], lb_tab[n]);
      wait_done(edge_n, sc, busy_ok);
      $display("degenerate l1=%0d l2=%0d score=%0d edge=%0d", la_tab[n], lb_tab[n], sc, edge_n);
      total++;
      if (sc !== SWIDTH'((la_tab[n] + lb_tab[n]) * INDEL)) begin
        bad++; $display("FAIL degen_score[%0d] got=%0d want=%0d", n, sc, (la_tab[n] + lb_tab[n]) * INDEL);
      end
      total++;
      if (edge_n != 1) begin bad++; $display("FAIL degen_latency[%0d] got=%0d want=1", n, edge_n); end
    end
  endtask

  task automatic test_back_to_back;
    int edge_n;
    int early_done;
    logic signed [SWIDTH-1:0] sc;
    bit busy_ok;
    early_done = 0;
    launch(32'h0000_0000, 32'h0000_0000, 16, 16);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) early_done++;
      if (k == 4) begin
        s1 = 32'hFFFF_FFFF;
        s2 = 32'h5555_5555;
        len1 = LWIDTH'(3);
        len2 = LWIDTH'(2);
        start = 1'b1;
      end
      if (k == 6) start = 1'b0;
    end
    total++;
    if (early_done != 0) begin bad++; $display("FAIL midrun_start_done got=%0d want=0", early_done); end
    wait_done(edge_n, sc, busy_ok);
    $display("maxlen AxA score=%0d edge=%0d", sc, edge_n);
    total++;
    if (sc !== SWIDTH'(16)) begin bad++; $display("FAIL maxlen_score got=%0d want=16", sc); end
    total++;
    if (edge_n != 22) begin bad++; $display("FAIL maxlen_latency got=%0d want=22", edge_n); end
    total++;
    if (!busy_ok) begin bad++; $display("FAIL maxlen_busy got=0 want=1"); end
    // Still inside the done cycle: request the next job immediately.
    s1 = 32'h0000_0000;
    s2 = 32'h5555_5555;
    len1 = LWIDTH'(16);
    len2 = LWIDTH'(16);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL b2b_done_clear got=%b want=0", done); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", busy); end
    total++;
    if (score !== SWIDTH'(16)) begin bad++; $display("FAIL b2b_score_hold got=%0d want=16", score); end
    wait_done(edge_n, sc, busy_ok);
    $display("b2b AxC score=%0d edge=%0d", sc, edge_n);
    total++;
    if (sc !== SWIDTH'(ref_nw(32'h0000_0000, 32'h5555_5555, 16, 16))) begin
      bad++; $display("FAIL b2b_score got=%0d want=%0d", sc, ref_nw(32'h0000_0000, 32'h5555_5555, 16, 16));
    end
    total++;
    if (edge_n != 32) begin bad++; $display("FAIL b2b_latency got=%0d want=32", edge_n); end
  endtask

  task automatic test_reset_midrun;
    int edge_n;
    int seen_done;
    logic signed [SWIDTH-1:0] sc;
    bit busy_ok;
    seen_done = 0;
    launch(enc("ACGT"), enc("ACGT"), 4, 4);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", busy); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL midreset_done got=%b want=0", done); end
    total++;
    if (score !== '0) begin bad++; $display("FAIL midreset_score got=%0d want=0", score); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen_done++;
    end
    total++;
    if (seen_done != 0) begin bad++; $display("FAIL midreset_no_done got=%0d want=0", seen_done); end
    launch(enc("ACGT"), enc("ACGT"), 4, 4);
    wait_done(edge_n, sc, busy_ok);
    $display("after reset ACGT vs ACGT score=%0d edge=%0d", sc, edge_n);
    total++;
    if (sc !== SWIDTH'(4) || edge_n != 8) begin
      bad++; $display("FAIL midreset_rerun got=%0d@%0d want=4@8", sc, edge_n);
    end
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [31:0] b;
    int la;
    int lb;
    int want;
    int edge_n;
    logic signed [SWIDTH-1:0] sc;
    bit busy_ok;
    for (int n = 0; n < 25; n++) begin
      a = $urandom;
      b = $urandom;
      la = $urandom_range(0, 20);
      lb = $urandom_range(0, 20);
      want = ref_nw(a, b, la, lb);
      launch(a, b, la, lb);
      wait_done(edge_n, sc, busy_ok);
      $display("random s1=%h l1=%0d s2=%h l2=%0d score=%0d edge=%0d", a, la, b, lb, sc, edge_n);
      total++;
      if (sc !== SWIDTH'(want)) begin
        bad++; $display("FAIL rand_score[%0d] got=%0d want=%0d", n, sc, want);
      end
      total++;
      if (edge_n != exp_latency(la, lb) || !busy_ok) begin
        bad++; $display("FAIL rand_latency[%0d] got=%0d busy_ok=%0d want=%0d", n, edge_n, busy_ok, exp_latency(la, lb));
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_known();
    test_degenerate();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
